// File: rtl/pls_rx.sv
// pls_rx: 10BASE-T PLS receiver - Manchester decode, carrier sense, end-of-frame and link integrity
// Ports:
//   clk_80mhz           sample clock (SPB samples per bit)
//   rst_ni              asynchronous reset, active low
//   rxd_in_p/rxd_in_n   asynchronous line receiver outputs
//   rxd_out/rxd_valid   decoded bit and its one-cycle strobe
//   rx_crs              carrier sense
//   rx_err              one-cycle error pulse (truncated frame or over-long link pulse)
//   link_ok             link integrity status
module pls_rx #(
    parameter int SPB          = 8,
    parameter int SYNC_BITS    = 4,
    parameter int ETD_SAMPLES  = 12,
    parameter int LP_MAX       = 16,
    parameter int LINK_PULSES  = 2,
    parameter int LINK_TIMEOUT = 8000000
) (
    input  logic clk_80mhz,
    input  logic rst_ni,
    input  logic rxd_in_p,
    input  logic rxd_in_n,
    output logic rxd_out,
    output logic rxd_valid,
    output logic rx_crs,
    output logic rx_err,
    output logic link_ok
);
    localparam int GW = $clog2(ETD_SAMPLES + 1);
    localparam int LW = $clog2(LP_MAX + 2);
    localparam int TW = $clog2(LINK_TIMEOUT + 1);
    localparam int EW = $clog2(SYNC_BITS + 1);
    localparam int PW = $clog2(LINK_PULSES + 1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t        state_q;
    logic [1:0]    p_sync_q, n_sync_q;
    logic          p_prev_q;
    logic [GW-1:0] gap_q;
    logic [EW-1:0] edge_cnt_q;
    logic [LW-1:0] lp_cnt_q;
    logic [TW-1:0] timer_q;
    logic [PW-1:0] pcnt_q;

    logic          p_s, n_s, p_edge, in_win, etd, mid, good, lp_end, lp_long, link_ev, tmo, reach;
    logic [GW-1:0] gap_d;

    assign p_s     = p_sync_q[1];
    assign n_s     = n_sync_q[1];
    assign p_edge  = p_s ^ p_prev_q;
    assign gap_d   = (gap_q == GW'(ETD_SAMPLES)) ? gap_q : gap_q + GW'(1);
    assign in_win  = (gap_q >= GW'(SPB / 2 + 1)) && (gap_q <= GW'(SPB + 3));
    // ETD takes priority over an edge arriving in the same sample
    assign etd     = (state_q == FRAME) && (gap_d == GW'(ETD_SAMPLES));
    // the first edge of a frame is always mid-bit: the preamble has no boundary edges
    assign mid     = (state_q == FRAME) && p_edge && !etd && ((edge_cnt_q == '0) || in_win);
    assign good    = etd && p_s;
    assign lp_end  = (state_q == IDLE) && !p_s && !n_s && (lp_cnt_q != '0) && (lp_cnt_q <= LW'(LP_MAX));
    assign lp_long = (state_q == IDLE) && !n_s && p_s && (lp_cnt_q == LW'(LP_MAX));
    assign link_ev = lp_end || good;
    assign tmo     = timer_q == TW'(LINK_TIMEOUT - 1);
    assign reach   = pcnt_q >= PW'(LINK_PULSES - 1);

    always_ff @(posedge clk_80mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            p_sync_q   <= '0;
            n_sync_q   <= '0;
            p_prev_q   <= 1'b0;
            gap_q      <= '0;
            edge_cnt_q <= '0;
            lp_cnt_q   <= '0;
            timer_q    <= '0;
            pcnt_q     <= '0;
            rxd_out    <= 1'b0;
            rxd_valid  <= 1'b0;
            rx_crs     <= 1'b0;
            rx_err     <= 1'b0;
            link_ok    <= 1'b0;
        end else begin
            p_sync_q   <= {p_sync_q[0], rxd_in_p};
            n_sync_q   <= {n_sync_q[0], rxd_in_n};
            p_prev_q   <= p_s;
            state_q    <= (state_q == IDLE) ? (n_s ? FRAME : IDLE) : (etd ? IDLE : FRAME);
            rx_crs     <= (state_q == IDLE) ? n_s : !etd;
            gap_q      <= (state_q == IDLE || mid) ? '0 : gap_d;
            edge_cnt_q <= (state_q == IDLE) ? '0 :
                          (mid && edge_cnt_q != EW'(SYNC_BITS)) ? edge_cnt_q + EW'(1) : edge_cnt_q;
            rxd_valid  <= mid && (edge_cnt_q == EW'(SYNC_BITS));
            rxd_out    <= mid ? p_s : rxd_out;
            rx_err     <= (etd && !p_s) || lp_long;
            // in a frame the counter is parked saturated so the ETD high after a frame earns no credit
            lp_cnt_q   <= (state_q == FRAME) ? LW'(LP_MAX + 1) :
                          !p_s ? '0 :
                          (lp_cnt_q == LW'(LP_MAX + 1)) ? lp_cnt_q : lp_cnt_q + LW'(1);
            timer_q    <= link_ev ? '0 : (timer_q == TW'(LINK_TIMEOUT)) ? timer_q : timer_q + TW'(1);
            pcnt_q     <= lp_end ? ((pcnt_q == PW'(LINK_PULSES)) ? pcnt_q : pcnt_q + PW'(1)) :
                          (tmo && !good) ? '0 : pcnt_q;
            link_ok    <= (good || (lp_end && reach)) ? 1'b1 : (tmo && !link_ev) ? 1'b0 : link_ok;
        end
    end
endmodule

// File: tb/tb_pls_rx.sv
// tb_pls_rx: directed bench for pls_rx - frames, truncation, jitter, link pulses, timeout, reset
module tb_pls_rx;
    logic clk_80mhz = 1'b0;
    logic rst_ni = 1'b0;
    logic rxd_in_p = 1'b0;
    logic rxd_in_n = 1'b0;
    logic rxd_out, rxd_valid, rx_crs, rx_err, link_ok;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pls_rx #(.LINK_TIMEOUT(2000)) dut (
        .clk_80mhz(clk_80mhz),
        .rst_ni(rst_ni),
        .rxd_in_p(rxd_in_p),
        .rxd_in_n(rxd_in_n),
        .rxd_out(rxd_out),
        .rxd_valid(rxd_valid),
        .rx_crs(rx_crs),
        .rx_err(rx_err),
        .link_ok(link_ok)
    );

    always #5 clk_80mhz = ~clk_80mhz;
    always @(posedge clk_80mhz) cyc++;

    logic rx_bits [0:1023];
    int   rx_n = 0, err_n = 0, rises = 0, last_v = 0, fall_c = 0, err_c = 0;
    logic crs_prev = 1'b0;

    always @(negedge clk_80mhz) begin
        if (rxd_valid) begin
            rx_bits[rx_n] = rxd_out;
            rx_n++;
            last_v = cyc;
            checks++;
            assert (rx_crs === 1'b1 && rx_err === 1'b0)
                else begin errors++; $error("FAIL valid_excl: crs=%b err=%b required crs=1 err=0", rx_crs, rx_err); end
        end
        if (rx_err) begin err_n++; err_c = cyc; end
        if (rx_crs && !crs_prev) rises++;
        if (!rx_crs && crs_prev) fall_c = cyc;
        crs_prev = rx_crs;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
            else begin errors++; $error("FAIL %s: got %0h expected %0h", tag, got, exp); end
    endtask

    function automatic logic [11:0] bits12(input int base);
        logic [11:0] v;
        for (int i = 0; i < 12; i++) v[i] = rx_bits[base + i];
        return v;
    endfunction

    // preamble 10101010 then 0xA5 LSB-first; mode 0 = ETD high tail, 1 = cut off to idle
    task automatic send_frame(input int mode, input bit jit, input int limit, output int c0);
        logic [15:0] fb;
        logic        half [0:31];
        logic        samp [0:127];
        int          k, j;
        fb = 16'hA555;
        c0 = 0;
        for (int b = 0; b < 16; b++) begin half[2*b] = ~fb[b]; half[2*b+1] = fb[b]; end
        for (int s = 0; s < 128; s++) samp[s] = half[s/4];
        if (jit) begin
            k = 0;
            for (int h = 1; h < 32; h++) if (half[h] != half[h-1]) begin
                j = (k % 4 == 1) ? 1 : (k % 4 == 3) ? -1 : 0;
                if (j == 1) samp[4*h] = half[h-1];
                if (j == -1) samp[4*h-1] = half[h];
                k++;
            end
        end
        for (int s = 0; s < 128; s++) begin
            if (s == limit) return;
            @(posedge clk_80mhz); #1;
            if (s == 0) c0 = cyc;
            rxd_in_p = samp[s];
            rxd_in_n = ~samp[s];
        end
        if (mode == 0) repeat (48) begin @(posedge clk_80mhz); #1; rxd_in_p = 1'b1; rxd_in_n = 1'b0; end
        @(posedge clk_80mhz); #1;
        rxd_in_p = 1'b0;
        rxd_in_n = 1'b0;
        repeat (40) @(posedge clk_80mhz);
    endtask

    task automatic pulse(input int len);
        repeat (len) begin @(posedge clk_80mhz); #1; rxd_in_p = 1'b1; end
        @(posedge clk_80mhz); #1;
        rxd_in_p = 1'b0;
        repeat (6) @(posedge clk_80mhz);
    endtask

    initial begin
        int base, eb, rb, c0;
        logic lk;
        repeat (3) @(posedge clk_80mhz);
        #1;
        chk("reset_outputs", 32'({rxd_out, rxd_valid, rx_crs, rx_err, link_ok}), 32'h0);
        rst_ni = 1'b1;
        repeat (5) @(posedge clk_80mhz);

        // over-long idle pulse: error, no carrier, no link credit
        eb = err_n; rb = rises;
        pulse(40);
        chk("long_pulse_err", 32'(err_n - eb), 32'd1);
        chk("long_pulse_crs", 32'(rises - rb), 32'd0);
        pulse(4);
        chk("link_after_1", 32'(link_ok), 32'd0);
        repeat (1000) @(posedge clk_80mhz);
        pulse(4);
        chk("link_after_2", 32'(link_ok), 32'd1);
        repeat (1900) @(posedge clk_80mhz);
        chk("link_before_tmo", 32'(link_ok), 32'd1);
        repeat (200) @(posedge clk_80mhz);
        chk("link_after_tmo", 32'(link_ok), 32'd0);

        // good frame
        base = rx_n; eb = err_n;
        send_frame(0, 1'b0, 999, c0);
        chk("good_count", 32'(rx_n - base), 32'd12);
        chk("good_bits", 32'(bits12(base)), 32'hA55);
        chk("good_latency", 32'(last_v - c0), 32'd127);
        chk("good_crs_drop", 32'(fall_c - last_v), 32'd12);
        chk("good_err", 32'(err_n - eb), 32'd0);
        chk("good_link", 32'(link_ok), 32'd1);
        chk("good_crs_idle", 32'(rx_crs), 32'd0);

        // truncated frame
        base = rx_n; eb = err_n; lk = link_ok;
        send_frame(1, 1'b0, 999, c0);
        chk("trunc_count", 32'(rx_n - base), 32'd12);
        chk("trunc_bits", 32'(bits12(base)), 32'hA55);
        chk("trunc_err", 32'(err_n - eb), 32'd1);
        chk("trunc_err_at_drop", 32'(err_c), 32'(fall_c));
        chk("trunc_link", 32'(link_ok), 32'(lk));

        // +/-1 sample edge jitter
        base = rx_n; eb = err_n;
        send_frame(0, 1'b1, 999, c0);
        chk("jit_count", 32'(rx_n - base), 32'd12);
        chk("jit_bits", 32'(bits12(base)), 32'hA55);
        chk("jit_err", 32'(err_n - eb), 32'd0);

        // asynchronous reset in the middle of a frame
        send_frame(0, 1'b0, 60, c0);
        #3;
        chk("pre_reset_crs", 32'(rx_crs), 32'd1);
        chk("pre_reset_link", 32'(link_ok), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midframe_reset", 32'({rxd_out, rxd_valid, rx_crs, rx_err, link_ok}), 32'h0);
        rxd_in_p = 1'b0;
        rxd_in_n = 1'b0;
        repeat (3) @(posedge clk_80mhz);
        #1 rst_ni = 1'b1;
        repeat (5) @(posedge clk_80mhz);
        base = rx_n; eb = err_n;
        send_frame(0, 1'b0, 999, c0);
        chk("post_reset_count", 32'(rx_n - base), 32'd12);
        chk("post_reset_bits", 32'(bits12(base)), 32'hA55);
        chk("post_reset_err", 32'(err_n - eb), 32'd0);
        chk("post_reset_link", 32'(link_ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
